// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path types and constants for the CPU step sequencer.
package cpu_ctrl_pkg;

  localparam int STEP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } seq_state_e;

  // Active-low G2 pair of the register-select decoder, both deasserted.
  localparam logic [1:0] DEC_G2_OFF = 2'b11;

endpackage

// File: rtl/step_sequencer_rise_detect.sv
// Rising-edge detector: registered previous value, pulse valid in the cycle the input is first seen high.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic prev_q;
  logic prev_d;

  assign prev_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/step_sequencer.sv
// T-state sequencer driving the register-select decoder: free-run, single-step,
// graceful halt at an instruction boundary and completed-instruction counting.
module step_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MAX_STEP = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt,
  input  logic              single_mode,
  input  logic              step_req,
  input  logic              last_step,
  output logic [STEP_W-1:0] step,
  output logic              dec_g1,
  output logic [1:0]        dec_g2,
  output logic              busy,
  output logic              instr_done,
  output logic [7:0]        instr_count
);

  localparam logic [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEP);

  seq_state_e        state_q, state_d;
  logic              active_q, active_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              done_q, done_d;
  logic [7:0]        count_q, count_d;

  logic step_pulse;
  logic instr_end;
  logic step_en;

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst   (rst),
    .d     (step_req),
    .pulse (step_pulse)
  );

  assign instr_end = active_q & (last_step | (step_q == MAX_S));
  assign step_en   = single_mode ? step_pulse : 1'b1;

  always_comb begin
    state_d  = state_q;
    active_d = 1'b0;
    step_d   = step_q;
    done_d   = 1'b0;
    count_d  = count_q;

    if (active_q) begin
      if (instr_end) begin
        step_d  = '0;
        count_d = count_q + 8'd1;
        done_d  = 1'b1;
      end else begin
        step_d = step_q + 3'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (start) begin
          state_d  = ST_RUN;
          active_d = step_en;
        end
      end
      ST_RUN: begin
        active_d = step_en;
        if (halt) state_d = ST_DRAIN;
      end
      // Once draining, only an instruction boundary ends it; halt is no longer looked at.
      ST_DRAIN: begin
        if (instr_end) begin
          state_d = ST_HALTED;
        end else begin
          active_d = step_en;
        end
      end
      ST_HALTED: begin
        if (start && !halt) begin
          state_d  = ST_RUN;
          step_d   = '0;
          active_d = step_en;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      active_q <= 1'b0;
      step_q   <= '0;
      done_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      step_q   <= step_d;
      done_q   <= done_d;
      count_q  <= count_d;
    end
  end

  assign step        = step_q;
  assign dec_g1      = active_q;
  assign dec_g2      = active_q ? 2'b00 : DEC_G2_OFF;
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign instr_done  = done_q;
  assign instr_count = count_q;

endmodule
